// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial unsigned subtractor: one full-subtractor slice, LSB first.
// Optional borrow input: define SERIAL_SUBTRACTOR_BORROW_IN_EN.
module serial_subtractor_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_SUBTRACTOR_BORROW_IN_EN
  input  logic             borrow_in,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state, nxt;
  logic [WIDTH-1:0] a_sh, b_sh, r_sh;
  logic [CW-1:0]    cnt;
  logic             br;
  logic             abit, bbit, dbit, br_nxt, last;

  assign abit   = a_sh[0];
  assign bbit   = b_sh[0];
  assign dbit   = abit ^ bbit ^ br;
  assign br_nxt = (~abit & bbit) | (~(abit ^ bbit) & br);
  assign last   = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt  = state;
    busy = 1'b0;
    done = 1'b0;
    unique case (state)
      S_IDLE: if (start) nxt = S_RUN;
      S_RUN: begin
        busy = 1'b1;
        if (last) nxt = S_DONE;
      end
      S_DONE: begin
        done = 1'b1;
        nxt  = S_IDLE;
      end
      default: nxt = S_IDLE;
    endcase
  end

  // Outputs only move on the final RUN edge, so they hold across operations.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh       <= '0;
      b_sh       <= '0;
      r_sh       <= '0;
      cnt        <= '0;
      br         <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            a_sh <= a;
            b_sh <= b;
            cnt  <= '0;
`ifdef SERIAL_SUBTRACTOR_BORROW_IN_EN
            br   <= borrow_in;
`else
            br   <= 1'b0;
`endif
          end
        end
        S_RUN: begin
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          r_sh <= {dbit, r_sh[WIDTH-1:1]};
          br   <= br_nxt;
          cnt  <= cnt + CW'(1);
          if (last) begin
            diff       <= {dbit, r_sh[WIDTH-1:1]};
            borrow_out <= br_nxt;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
